// File: rtl/cclimb_pkg.sv
// Shared types and default ROM map constants for the Crazy Climber download path.
`timescale 1ns/1ps
package cclimb_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} dl_state_t;
  typedef enum logic [1:0] {RGN_CPU, RGN_GFX, RGN_SND, RGN_PROM} rom_region_t;

  localparam logic [15:0] CPU_END_DEF   = 16'h6000;
  localparam logic [15:0] GFX_END_DEF   = 16'h9000;
  localparam logic [15:0] SND_END_DEF   = 16'hB000;
  localparam logic [15:0] IMG_BYTES_DEF = 16'hB060;
  localparam int unsigned SETTLE_CE_DEF = 16;

endpackage

// File: rtl/rom_region_dec.sv
// Combinational ROM address to region decode; each bound is an exclusive upper limit.
`timescale 1ns/1ps
module rom_region_dec
  import cclimb_pkg::*;
#(
  parameter logic [15:0] CPU_END = CPU_END_DEF,
  parameter logic [15:0] GFX_END = GFX_END_DEF,
  parameter logic [15:0] SND_END = SND_END_DEF
) (
  input  logic [15:0] addr_i,
  output rom_region_t region_o
);

  always_comb begin
    region_o = RGN_PROM;
    if (addr_i < CPU_END)      region_o = RGN_CPU;
    else if (addr_i < GFX_END) region_o = RGN_GFX;
    else if (addr_i < SND_END) region_o = RGN_SND;
  end

endmodule

// File: rtl/rom_dl_ctrl.sv
// Download sequencer: forwards ioctl bytes to the ROM write port, checks image size,
// and holds the core in reset until a settle period of ce pulses has elapsed.
`timescale 1ns/1ps
module rom_dl_ctrl
  import cclimb_pkg::*;
#(
  parameter logic [15:0] CPU_END   = CPU_END_DEF,
  parameter logic [15:0] GFX_END   = GFX_END_DEF,
  parameter logic [15:0] SND_END   = SND_END_DEF,
  parameter logic [15:0] IMG_BYTES = IMG_BYTES_DEF,
  parameter int unsigned SETTLE_CE = SETTLE_CE_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        user_rst,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [1:0]  dn_region,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_err,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CE - 1);

  dl_state_t   state_q, state_d;
  logic        dl_q;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        ovf_q, ovf_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic        load_ok_q, load_ok_d;
  logic        load_err_q, load_err_d;
  logic [15:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic        dn_wr_q, dn_wr_d;
  rom_region_t dn_region_q, dn_region_d;
  logic        core_reset_q;
  rom_region_t rgn;
  logic        dl_rise, dl_fall;

  rom_region_dec #(
    .CPU_END (CPU_END),
    .GFX_END (GFX_END),
    .SND_END (SND_END)
  ) u_dec (
    .addr_i   (ioctl_addr[15:0]),
    .region_o (rgn)
  );

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;

  // dn_wr is a single-cycle valid with no ready: the ROM port must accept every
  // strobe, and dn_addr/dn_data/dn_region are only meaningful while dn_wr is high.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    ovf_d        = ovf_q;
    settle_cnt_d = settle_cnt_q;
    load_ok_d    = load_ok_q;
    load_err_d   = load_err_q;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    dn_region_d  = dn_region_q;
    dn_wr_d      = 1'b0;

    if (dl_rise) begin
      state_d      = LOAD;
      byte_cnt_d   = '0;
      ovf_d        = 1'b0;
      settle_cnt_d = '0;
      load_ok_d    = 1'b0;
      load_err_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (dl_fall) begin
            state_d      = SETTLE;
            settle_cnt_d = '0;
            load_ok_d    = (byte_cnt_q >= IMG_BYTES) && !ovf_q;
            load_err_d   = (byte_cnt_q < IMG_BYTES) || ovf_q;
          end else if (ioctl_wr) begin
            if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
            if (|ioctl_addr[24:16]) begin
              ovf_d = 1'b1;
            end else begin
              dn_wr_d     = 1'b1;
              dn_addr_d   = ioctl_addr[15:0];
              dn_data_d   = ioctl_dout;
              dn_region_d = rgn;
            end
          end
        end
        SETTLE: begin
          if (user_rst) begin
            settle_cnt_d = '0;
          end else if (ce) begin
            // Leave on the final ce itself so the next ce is the first unreset core edge.
            if (settle_cnt_q == SETTLE_LAST) begin
              state_d      = RUN;
              settle_cnt_d = '0;
            end else begin
              settle_cnt_d = settle_cnt_q + 16'd1;
            end
          end
        end
        RUN: begin
          if (user_rst) begin
            state_d      = SETTLE;
            settle_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dl_q         <= 1'b0;
      byte_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      settle_cnt_q <= '0;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_wr_q      <= 1'b0;
      dn_region_q  <= RGN_CPU;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      byte_cnt_q   <= byte_cnt_d;
      ovf_q        <= ovf_d;
      settle_cnt_q <= settle_cnt_d;
      load_ok_q    <= load_ok_d;
      load_err_q   <= load_err_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_wr_q      <= dn_wr_d;
      dn_region_q  <= dn_region_d;
      core_reset_q <= (state_d != RUN);
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign dn_region  = dn_region_q;
  assign core_reset = core_reset_q;
  assign load_ok    = load_ok_q;
  assign load_err   = load_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Self-checking bench for rom_dl_ctrl: scoreboard of expected ROM writes plus
// status/reset-release checks derived from a byte-count model of each download.
`timescale 1ns/1ps
module tb_rom_dl_ctrl;

  localparam int W         = 58;
  localparam int IMG       = 'hB060;
  localparam int SETTLE_N  = 16;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_SETTLE = 2'd2, S_RUN = 2'd3;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ce = 1'b0;
  logic        user_rst;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [1:0]  dn_region;
  logic        core_reset;
  logic        load_ok;
  logic        load_err;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_cnt   = 0;
  bit m_ovf   = 1'b0;
  logic [W-1:0] exp_q[$];

  rom_dl_ctrl dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ce             (ce),
    .user_rst       (user_rst),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_region      (dn_region),
    .core_reset     (core_reset),
    .load_ok        (load_ok),
    .load_err       (load_err),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      ce = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_region(input logic [15:0] a);
    if (a < 16'h6000) return 2'd0;
    if (a < 16'h9000) return 2'd1;
    if (a < 16'hB000) return 2'd2;
    return 2'd3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (m_cnt < 'hFFFF) m_cnt++;
    if (a[24:16] == 9'd0) exp_q.push_back({32'(cyc + 1), a[15:0], d, ref_region(a[15:0])});
    else m_ovf = 1'b1;
    step();
  endtask

  task automatic start_download();
    ioctl_download = 1'b1;
    m_cnt = 0;
    m_ovf = 1'b0;
    step();
    check("enter_load_state", 32'(dbg_state), 32'(S_LOAD));
    check("enter_load_flags", {30'd0, load_ok, load_err}, 32'd0);
    check("enter_load_reset", 32'(core_reset), 32'd1);
  endtask

  task automatic wait_release();
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk_sys);
      if (ce) n++;
      #1;
      if (!core_reset) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL release_timeout: core_reset still 1 after %0d ce pulses", n);
    end else begin
      check("release_ce_count", 32'(n), 32'(SETTLE_N));
      check("release_state", 32'(dbg_state), 32'(S_RUN));
    end
  endtask

  task automatic end_download();
    bit exp_ok, exp_err;
    exp_ok  = !m_ovf && (m_cnt >= IMG);
    exp_err = m_ovf || (m_cnt < IMG);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    step();
    check("load_ok", 32'(load_ok), 32'(exp_ok));
    check("load_err", 32'(load_err), 32'(exp_err));
    check("settle_reset", 32'(core_reset), 32'd1);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    wait_release();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_sys) begin
    if (dn_wr === 1'b1) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      n_tests++;
      a = {32'(cyc), dn_addr, dn_data, dn_region};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dn_wr_unexpected: got cyc=%0d addr=%h data=%h rgn=%0d expected no write",
                 cyc, dn_addr, dn_data, dn_region);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL dn_write: got cyc=%0d addr=%h data=%h rgn=%0d expected cyc=%0d addr=%h data=%h rgn=%0d",
                   a[57:26], a[25:10], a[9:2], a[1:0], e[57:26], e[25:10], e[9:2], e[1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] bounds [6];

  initial begin
    bounds = '{16'h5FFF, 16'h6000, 16'h8FFF, 16'h9000, 16'hAFFF, 16'hB000};
    reset_n        = 1'b0;
    user_rst       = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    repeat (3) step();
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_dn", {dn_addr, dn_data, 5'd0, dn_wr, dn_region}, 32'd0);
    check("rst_flags", {30'd0, load_ok, load_err}, 32'd0);
    reset_n = 1'b1;

    // Idle with ce running and stray strobes: no run, no writes.
    user_rst = 1'b1;
    repeat (5) step();
    user_rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ioctl_wr   = (i % 3 == 0);
      ioctl_addr = 25'($urandom_range(0, 'hFFFF));
      step();
    end
    ioctl_wr = 1'b0;
    check("idle_no_run_state", 32'(dbg_state), 32'(S_IDLE));
    check("idle_no_run_reset", 32'(core_reset), 32'd1);

    // Full image, back-to-back strobes.
    start_download();
    for (int i = 0; i < IMG; i++) send_byte(25'(i), 8'($urandom));
    end_download();

    // Strobes outside LOAD are ignored.
    for (int i = 0; i < 8; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'($urandom_range(0, 'hFFFF));
      step();
    end
    ioctl_wr = 1'b0;
    step();

    // User reset in RUN for three cycles.
    user_rst = 1'b1;
    step();
    check("user_rst_reset", 32'(core_reset), 32'd1);
    check("user_rst_state", 32'(dbg_state), 32'(S_SETTLE));
    step();
    step();
    user_rst = 1'b0;
    wait_release();

    // Region boundaries with random gaps.
    start_download();
    for (int i = 0; i < 6; i++) begin
      send_byte({9'd0, bounds[i]}, 8'($urandom));
      ioctl_wr = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    end_download();

    // Address beyond 64 KiB.
    start_download();
    send_byte(25'h00010, 8'h11);
    send_byte(25'h10005, 8'h22);
    send_byte(25'h00011, 8'h33);
    end_download();

    // Random addresses, occasional high bits, random gaps.
    start_download();
    for (int i = 0; i < 200; i++) begin
      logic [24:0] a;
      a = 25'($urandom_range(0, 'hFFFF));
      if ($urandom_range(0, 15) == 0) a[24:16] = 9'($urandom_range(1, 511));
      send_byte(a, 8'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        ioctl_wr = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
    end
    end_download();

    // Download start and user reset together: LOAD wins.
    ioctl_download = 1'b1;
    user_rst       = 1'b1;
    m_cnt = 0;
    m_ovf = 1'b0;
    step();
    check("rise_vs_user_rst", 32'(dbg_state), 32'(S_LOAD));
    user_rst = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(25'($urandom_range(0, 'hFFFF)), 8'($urandom));
    end_download();

    // Short load.
    start_download();
    for (int i = 0; i < 'h8000; i++) send_byte(25'(i), 8'($urandom));
    end_download();

    // Asynchronous reset mid-load drops the in-flight write.
    start_download();
    for (int i = 0; i < 'h100; i++) send_byte(25'(i), 8'($urandom));
    reset_n        = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_dn_wr", 32'(dn_wr), 32'd0);
    check("midrst_reset", 32'(core_reset), 32'd1);
    check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    repeat (2) step();
    reset_n = 1'b1;
    step();
    start_download();
    for (int i = 0; i < 'h10; i++) send_byte(25'(i + 'h200), 8'($urandom));
    end_download();

    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
